// File: rtl/izh_scheduler.sv
// Time-multiplexes one combinational Izhikevich update datapath across N_NEURONS
// virtual neurons. Per-neuron state and currents live in local register arrays.
module izh_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cur_we,
    input  logic [IDX_W-1:0]     cur_addr,
    input  logic [7:0]           cur_data,
    output logic [7:0]           dp_v,
    output logic [15:0]          dp_u,
    output logic [7:0]           dp_i,
    input  logic [7:0]           dp_v_next,
    input  logic [15:0]          dp_u_next,
    input  logic                 dp_spike,
    output logic                 busy,
    output logic                 done,
    output logic                 spike_valid,
    output logic [IDX_W-1:0]     spike_id,
    output logic [N_NEURONS-1:0] spike_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W:0]   NUM      = (IDX_W + 1)'(N_NEURONS);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;

    logic [7:0]  v_mem   [N_NEURONS];
    logic [15:0] u_mem   [N_NEURONS];
    logic [7:0]  cur_mem [N_NEURONS];

    logic [7:0]  op_v, op_i, res_v;
    logic [15:0] op_u, res_u;
    logic        res_spike;

    assign dp_v = op_v;
    assign dp_u = op_u;
    assign dp_i = op_i;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        spike_valid = 1'b0;
        spike_id    = '0;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: begin
                busy     = 1'b1;
                state_nx = S_EVAL;
            end
            S_EVAL: begin
                busy     = 1'b1;
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                busy        = 1'b1;
                spike_valid = res_spike;
                spike_id    = res_spike ? idx : '0;
                state_nx    = (idx == LAST_IDX) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            op_v      <= '0;
            op_u      <= '0;
            op_i      <= '0;
            res_v     <= '0;
            res_u     <= '0;
            res_spike <= 1'b0;
            spike_vec <= '0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                v_mem[i]   <= '0;
                u_mem[i]   <= '0;
                cur_mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        spike_vec <= '0;
                    end
                end
                S_FETCH: begin
                    op_v <= v_mem[idx];
                    op_u <= u_mem[idx];
                    op_i <= cur_mem[idx];
                end
                S_EVAL: begin
                    res_v     <= dp_v_next;
                    res_u     <= dp_u_next;
                    res_spike <= dp_spike;
                end
                S_WRITE: begin
                    v_mem[idx] <= res_v;
                    u_mem[idx] <= res_u;
                    if (res_spike) spike_vec[idx] <= 1'b1;
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                default: ;
            endcase
            // Same-edge write lands after FETCH has sampled the old current.
            if (cur_we && ({1'b0, cur_addr} < NUM)) cur_mem[cur_addr] <= cur_data;
        end
    end

endmodule

// File: tb/tb_izh_scheduler.sv
// Randomized and directed bench for izh_scheduler against a timeline-based
// behavioural model, with a stub datapath v+i / u+1 / spike when v>=208.
module tb_izh_scheduler;

    localparam int NM = 4;

    logic        clk;
    logic        reset, start, cur_we;
    logic [1:0]  cur_addr;
    logic [7:0]  cur_data;
    logic [7:0]  dp_v, dp_i, dp_v_next;
    logic [15:0] dp_u, dp_u_next;
    logic        dp_spike, busy, done, spike_valid;
    logic [1:0]  spike_id;
    logic [3:0]  spike_vec;

    logic        start3, cur_we3;
    logic [1:0]  cur_addr3;
    logic [7:0]  cur_data3;
    logic [7:0]  dp_v3, dp_i3, dp_v_next3;
    logic [15:0] dp_u3, dp_u_next3;
    logic        dp_spike3, busy3, done3, spike_valid3;
    logic [1:0]  spike_id3;
    logic [2:0]  spike_vec3;

    int total  = 0;
    int passed = 0;

    assign dp_v_next  = dp_v + dp_i;
    assign dp_u_next  = dp_u + 16'd1;
    assign dp_spike   = (dp_v >= 8'd208);
    assign dp_v_next3 = dp_v3 + dp_i3;
    assign dp_u_next3 = dp_u3 + 16'd1;
    assign dp_spike3  = (dp_v3 >= 8'd208);

    izh_scheduler #(.N_NEURONS(4), .IDX_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .cur_we(cur_we),
        .cur_addr(cur_addr), .cur_data(cur_data),
        .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
        .dp_v_next(dp_v_next), .dp_u_next(dp_u_next), .dp_spike(dp_spike),
        .busy(busy), .done(done), .spike_valid(spike_valid),
        .spike_id(spike_id), .spike_vec(spike_vec)
    );

    izh_scheduler #(.N_NEURONS(3), .IDX_W(2)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .cur_we(cur_we3),
        .cur_addr(cur_addr3), .cur_data(cur_data3),
        .dp_v(dp_v3), .dp_u(dp_u3), .dp_i(dp_i3),
        .dp_v_next(dp_v_next3), .dp_u_next(dp_u_next3), .dp_spike(dp_spike3),
        .busy(busy3), .done(done3), .spike_valid(spike_valid3),
        .spike_id(spike_id3), .spike_vec(spike_vec3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: m_t is the cycle number since the accepted start (0 = idle).
    // Cycle 3k+1 fetches neuron k, cycle 3k+3 writes it, cycle 3N+1 is done.
    int          m_t, m_k;
    logic [7:0]  mv [NM];
    logic [15:0] mu [NM];
    logic [7:0]  mc [NM];
    logic [7:0]  m_ov, m_oi;
    logic [15:0] m_ou;
    logic [3:0]  m_sv;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NM; i++) begin
                mv[i] = 0; mu[i] = 0; mc[i] = 0;
            end
            m_ov = 0; m_ou = 0; m_oi = 0; m_sv = 0; m_t = 0;
        end else begin
            if (m_t >= 1 && m_t <= 3 * NM) begin
                m_k = (m_t - 1) / 3;
                if (m_t % 3 == 1) begin
                    m_ov = mv[m_k]; m_ou = mu[m_k]; m_oi = mc[m_k];
                end else if (m_t % 3 == 0) begin
                    mv[m_k] = m_ov + m_oi;
                    mu[m_k] = m_ou + 16'd1;
                    if (m_ov >= 8'd208) m_sv[m_k] = 1'b1;
                end
            end
            if (cur_we && int'(cur_addr) < NM) mc[cur_addr] = cur_data;
            if (m_t == 0) begin
                if (start) begin
                    m_t  = 1;
                    m_sv = 0;
                end
            end else if (m_t == 3 * NM + 1) m_t = 0;
            else m_t++;
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_done, e_sv;
        e_busy = (m_t >= 1 && m_t <= 3 * NM);
        e_done = (m_t == 3 * NM + 1);
        e_sv   = e_busy && (m_t % 3 == 0) && (m_ov >= 8'd208);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("spike_valid", spike_valid, e_sv);
        if (e_sv) chk("spike_id", spike_id, m_t / 3 - 1);
        chk("spike_vec", spike_vec, m_sv);
        chk("dp_v", dp_v, m_ov);
        chk("dp_u", dp_u, m_ou);
        chk("dp_i", dp_i, m_oi);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one step; inj_start pulses start mid-step and in the done cycle,
    // wr_c writes cur[1]=50 in that cycle, rst_at asserts reset in that cycle.
    task automatic run_step(input int inj_start, input int wr_c, input int rst_at,
                            output int cyc, output int nbusy, output int nsv,
                            output int last_id, output int dpi5, output int extra_done);
        cyc = -1; nbusy = 0; nsv = 0; last_id = -1; dpi5 = 0; extra_done = 0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 60; c++) begin
            start  = 1'b0;
            cur_we = 1'b0;
            if (busy) nbusy++;
            if (spike_valid) begin
                nsv++;
                last_id = spike_id;
            end
            if (c == 5) dpi5 = dp_i;
            if (c == rst_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("reset_abort_outputs",
                    {dp_v, dp_u, dp_i, busy, done, spike_valid, spike_id, spike_vec}, 0);
                return;
            end
            if (done) begin
                cyc = c;
                if (inj_start != 0) start = 1'b1;
                tick();
                start = 1'b0;
                break;
            end
            if (inj_start != 0 && c == 5) start = 1'b1;
            if (c == wr_c) begin
                cur_we = 1'b1; cur_addr = 2'd1; cur_data = 8'd50;
            end
            tick();
        end
        start = 1'b0; cur_we = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) extra_done++;
            tick();
        end
        chk("step_timeout", (cyc == -1), 0);
    endtask

    initial begin
        int cyc, nb, ns, lid, d5, xd, c3, maxi;
        reset = 1'b1; start = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = '0;
        start3 = 1'b0; cur_we3 = 1'b0; cur_addr3 = '0; cur_data3 = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_state",
            {dp_v, dp_u, dp_i, busy, done, spike_valid, spike_id, spike_vec}, 0);

        run_step(0, 0, 0, cyc, nb, ns, lid, d5, xd);
        chk("stepA_cycles", cyc, 13);
        chk("stepA_busy_cycles", nb, 12);
        chk("stepA_spikes", ns, 0);
        chk("stepA_spike_vec", spike_vec, 4'b0000);

        cur_we = 1'b1; cur_addr = 2'd2; cur_data = 8'd110;
        tick();
        cur_we = 1'b0;

        run_step(0, 0, 0, cyc, nb, ns, lid, d5, xd);
        chk("stepB_spikes", ns, 0);
        chk("stepB_last_dp_u", dp_u, 1);
        run_step(0, 0, 0, cyc, nb, ns, lid, d5, xd);
        chk("stepC_spikes", ns, 0);
        chk("stepC_last_dp_v", dp_v, 0);

        run_step(1, 0, 0, cyc, nb, ns, lid, d5, xd);
        chk("stepD_cycles", cyc, 13);
        chk("stepD_spikes", ns, 1);
        chk("stepD_spike_id", lid, 2);
        chk("stepD_spike_vec", spike_vec, 4'b0100);
        chk("stepD_extra_done", xd, 0);

        run_step(0, 4, 0, cyc, nb, ns, lid, d5, xd);
        chk("stepE_dp_i_old", d5, 0);
        run_step(0, 0, 0, cyc, nb, ns, lid, d5, xd);
        chk("stepF_dp_i_new", d5, 50);

        run_step(0, 0, 11, cyc, nb, ns, lid, d5, xd);
        run_step(0, 0, 0, cyc, nb, ns, lid, d5, xd);
        chk("after_reset_cycles", cyc, 13);
        chk("after_reset_busy", nb, 12);

        for (int n = 0; n < 600; n++) begin
            start    = ($urandom_range(0, 5) == 0);
            cur_we   = ($urandom_range(0, 2) == 0);
            cur_addr = 2'($urandom_range(0, 3));
            cur_data = 8'($urandom_range(0, 255));
            reset    = ($urandom_range(0, 199) == 0);
            tick();
        end
        start = 1'b0; cur_we = 1'b0; reset = 1'b0;
        for (int n = 0; n < 16; n++) tick();

        cur_we3 = 1'b1; cur_addr3 = 2'd3; cur_data3 = 8'd99;
        tick();
        cur_we3 = 1'b0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        c3 = -1; maxi = 0;
        for (int c = 1; c <= 40; c++) begin
            if (int'(dp_i3) > maxi) maxi = dp_i3;
            if (done3) begin
                c3 = c;
                break;
            end
            tick();
        end
        chk("n3_cycles", c3, 10);
        chk("n3_ignored_write", maxi, 0);
        tick();

        cur_we3 = 1'b1; cur_addr3 = 2'd2; cur_data3 = 8'd7;
        tick();
        cur_we3 = 1'b0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        c3 = -1; maxi = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 8) maxi = dp_i3;
            if (done3) begin
                c3 = c;
                break;
            end
            tick();
        end
        chk("n3_valid_write_dp_i", maxi, 7);
        chk("n3_cycles_2", c3, 10);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
